oak8m14_ram_arbiter: RTL
========================

OAK8M14_RAM_ARBITER -- requirements
Module: oak8m14_ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, sample-RAM address width.
REQ-002 Parameter: TIMEOUT, 15, maximum cycles to wait for ram_ack (only with OAK8M14_ARB_TIMEOUT_EN).
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rstb  in  1  reset, synchronous, active-low.
REQ-005 Port: wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Caravel Wishbone request; WB request = cyc & stb.
REQ-006 Port: wbs_adr_i  in  ADDR_W  WB address; wbs_dat_i  in  8  WB write data.
REQ-007 Port: wbs_dat_o  out  8  WB read data; wbs_ack_o  out  1  WB acknowledge.
REQ-008 Port: pb_req  in  1  playback read request; pb_addr  in  ADDR_W  playback address.
REQ-009 Port: pb_data  out  8  playback read data; pb_ack  out  1  playback acknowledge.
REQ-010 Port: ram_stb, ram_we  out  1 each  RAM strobe and write enable; ram_addr  out  ADDR_W; ram_wdata  out  8.
REQ-011 Port: ram_rdata  in  8; ram_ack  in  1  RAM completion, arbitrary latency >= 1 cycle.
REQ-012 Port: arb_err  out  1  one-cycle pulse on RAM timeout.
REQ-013 Port: dbg_ram_wb_stb  out  1  equals ram_stb; dbg_caravel_wb_stb  out  1  equals wbs_cyc_i & wbs_stb_i.

Function
REQ-014 FSM states: IDLE, BUSY_PB, BUSY_WB, DONE; all outputs registered except the dbg_* outputs.
REQ-015 IDLE, only pb_req: go to BUSY_PB; ram_stb=1, ram_we=0, ram_addr=pb_addr on the next cycle.
REQ-016 IDLE, only WB request: go to BUSY_WB; ram_stb=1, ram_we=wbs_we_i, ram_addr=wbs_adr_i, ram_wdata=wbs_dat_i on the next cycle.
REQ-017 IDLE, both requests in the same cycle: grant the requester not granted last (round-robin via last_grant); last_grant updates on every grant.
REQ-018 BUSY_*: ram_stb, ram_we, ram_addr and ram_wdata are held stable until ram_ack.
REQ-019 BUSY_* with ram_ack=1: next cycle ram_stb=0, the granted ack is 1 for exactly one cycle, and pb_data or wbs_dat_o = ram_rdata captured on the ram_ack cycle; state goes to DONE.
REQ-020 Write data: wbs_dat_o is not updated on WB writes and holds its last value.
REQ-021 DONE lasts exactly one cycle, then IDLE; requests are not sampled in DONE, so minimum request-to-request spacing is 4 cycles with a 1-cycle RAM.
REQ-022 Latency: request in IDLE at cycle N gives ram_stb at N+1; ram_ack at cycle M gives requester ack at M+1.
REQ-023 WB cyc deasserted during BUSY_WB: the RAM cycle completes, wbs_ack_o is suppressed, and state goes to DONE normally.
REQ-024 ram_ack outside BUSY_*: ignored.
REQ-025 pb_ack and wbs_ack_o are never 1 in the same cycle.

Reset
REQ-026 rstb=0 at a clock edge: state=IDLE, last_grant=WB, ram_stb=0, ram_we=0, ram_addr=0, ram_wdata=0, pb_ack=0, pb_data=0, wbs_ack_o=0, wbs_dat_o=0, arb_err=0, timeout counter=0.
REQ-027 Reset during BUSY_*: the RAM cycle is abandoned (ram_stb=0 next cycle) and no ack is issued.

Configuration
REQ-028 OAK8M14_ARB_TIMEOUT_EN defined: a counter clears on entry to BUSY_* and increments each BUSY cycle.
REQ-029 Timeout: if the counter reaches TIMEOUT without ram_ack, then next cycle ram_stb=0, the granted ack pulses with data 8'hFF, arb_err pulses for one cycle, and state goes to DONE.
REQ-030 OAK8M14_ARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, and arb_err is tied to 0.

Verification
REQ-031 Reset, then pb_req=1 with pb_addr=8'h10, RAM returns 8'hA5 after 2 cycles -> ram_stb at N+1, pb_ack=1 and pb_data=8'hA5 for one cycle.
REQ-032 WB write adr=8'h03, dat=8'h5A -> ram_we=1, ram_addr=8'h03, ram_wdata=8'h5A; wbs_ack_o pulses once; wbs_dat_o unchanged.
REQ-033 pb_req and WB read raised in the same cycle, held for two transactions -> grant order PB, WB, PB, WB; acks never overlap.
REQ-034 WB read with cyc dropped during BUSY_WB -> ram_stb completes, no wbs_ack_o, next request is served normally.
REQ-035 rstb=0 in the middle of BUSY_PB -> next cycle all outputs are at reset values, no pb_ack, state is IDLE.
REQ-036 Macro defined, RAM never acks -> after 15 BUSY cycles the ack pulses with 8'hFF and arb_err=1 for one cycle; macro undefined -> ram_stb is still 1 after 100 cycles and arb_err stays 0.

Source files
------------

// File: rtl/oak8m14_ram_arbiter_if.sv
// Bus bundle for oak8m14_ram_arbiter: Caravel Wishbone, playback and RAM.
// master = arbiter side, slave = surrounding system.
interface oak8m14_ram_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [ADDR_W-1:0] wbs_adr_i;
  logic [7:0]        wbs_dat_i;
  logic [7:0]        wbs_dat_o;
  logic              wbs_ack_o;
  logic              pb_req;
  logic [ADDR_W-1:0] pb_addr;
  logic [7:0]        pb_data;
  logic              pb_ack;
  logic              ram_stb;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              ram_ack;

  modport master (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o,
    input  pb_req, pb_addr,
    output pb_data, pb_ack,
    output ram_stb, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o,
    output pb_req, pb_addr,
    input  pb_data, pb_ack,
    input  ram_stb, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/oak8m14_ram_arbiter.sv
// Round-robin sample-RAM arbiter between Caravel Wishbone and playback.
// Optional RAM ack timeout: define OAK8M14_ARB_TIMEOUT_EN.
module oak8m14_ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rstb,
  oak8m14_ram_arbiter_if.master bus,
  output logic arb_err,
  output logic dbg_ram_wb_stb,
  output logic dbg_caravel_wb_stb
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_PB,
    BUSY_WB,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic              last_wb_q, last_wb_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              pb_ack_q, pb_ack_d;
  logic [7:0]        pb_data_q, pb_data_d;
  logic              wb_ack_q, wb_ack_d;
  logic [7:0]        wb_dat_q, wb_dat_d;
  logic              abort_q, abort_d;
  logic              wb_req;
  logic              busy;
  logic              tmo;
  logic [7:0]        rsp;

  assign wb_req = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign busy   = (state_q == BUSY_PB) || (state_q == BUSY_WB);
  assign rsp    = bus.ram_ack ? bus.ram_rdata : 8'hFF;

`ifdef OAK8M14_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
  assign arb_err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
      err_d = tmo & ~bus.ram_ack;
    end
  end
`else
  assign tmo     = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_wb_d = last_wb_q;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pb_ack_d  = 1'b0;
    pb_data_d = pb_data_q;
    wb_ack_d  = 1'b0;
    wb_dat_d  = wb_dat_q;
    abort_d   = abort_q;
    unique case (state_q)
      IDLE: begin
        if (bus.pb_req && (!wb_req || last_wb_q)) begin
          state_d   = BUSY_PB;
          last_wb_d = 1'b0;
          stb_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = bus.pb_addr;
        end else if (wb_req) begin
          state_d   = BUSY_WB;
          last_wb_d = 1'b1;
          stb_d     = 1'b1;
          we_d      = bus.wbs_we_i;
          addr_d    = bus.wbs_adr_i;
          wdata_d   = bus.wbs_dat_i;
          abort_d   = 1'b0;
        end
      end
      BUSY_PB: begin
        if (bus.ram_ack || tmo) begin
          state_d   = DONE;
          stb_d     = 1'b0;
          pb_ack_d  = 1'b1;
          pb_data_d = rsp;
        end
      end
      BUSY_WB: begin
        // a master that dropped cyc mid-cycle is not acked
        if (!bus.wbs_cyc_i) abort_d = 1'b1;
        if (bus.ram_ack || tmo) begin
          state_d  = DONE;
          stb_d    = 1'b0;
          wb_ack_d = bus.wbs_cyc_i & ~abort_q;
          if (wb_ack_d && !we_q) wb_dat_d = rsp;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= IDLE;
      last_wb_q <= 1'b1;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pb_ack_q  <= 1'b0;
      pb_data_q <= '0;
      wb_ack_q  <= 1'b0;
      wb_dat_q  <= '0;
      abort_q   <= 1'b0;
`ifdef OAK8M14_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_wb_q <= last_wb_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pb_ack_q  <= pb_ack_d;
      pb_data_q <= pb_data_d;
      wb_ack_q  <= wb_ack_d;
      wb_dat_q  <= wb_dat_d;
      abort_q   <= abort_d;
`ifdef OAK8M14_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.ram_stb   = stb_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.pb_ack    = pb_ack_q;
  assign bus.pb_data   = pb_data_q;
  assign bus.wbs_ack_o = wb_ack_q;
  assign bus.wbs_dat_o = wb_dat_q;

  assign dbg_ram_wb_stb     = stb_q;
  assign dbg_caravel_wb_stb = wb_req;

endmodule
